// File: rtl/risc_wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued multi-cycle results.
// Define RISC_WB_ARB_BYPASS_EN to let an mc result skip the empty FIFO when the pipe is idle.
module risc_wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_rw,
  input  logic [ADDR_W-1:0]            pipe_da,
  input  logic [DATA_W-1:0]            pipe_bus_d,
  input  logic                         mc_valid,
  output logic                         mc_ready,
  input  logic [ADDR_W-1:0]            mc_da,
  input  logic [DATA_W-1:0]            mc_data,
  output logic                         pipe_stall,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_addr,
  output logic [DATA_W-1:0]            rf_data,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic [(1<<ADDR_W)-1:0]       q_busy_mask
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int PW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE_MAX+1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

  logic [ADDR_W-1:0] mem_da_q   [QDEPTH];
  logic [DATA_W-1:0] mem_data_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic preq, qreq, q_grant, p_grant, byp_grant, push, pop;
  logic [ADDR_W-1:0] head_da;
  logic [DATA_W-1:0] head_data;

  assign head_da   = mem_da_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  assign preq    = pipe_rw && (pipe_da != '0);
  assign qreq    = (count_q != '0);
  assign q_grant = qreq && (!preq || (starve_q == SMAX));
  assign p_grant = preq && !q_grant;

`ifdef RISC_WB_ARB_BYPASS_EN
  assign byp_grant = !qreq && !preq && mc_valid;
`else
  assign byp_grant = 1'b0;
`endif

  // mc_ready depends only on registered occupancy, so a same-cycle pop cannot raise it.
  assign mc_ready   = (count_q < QFULL);
  assign push       = mc_valid && mc_ready && !byp_grant;
  assign pop        = q_grant;
  assign pipe_stall = q_grant && preq;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (q_grant || !qreq)
      starve_d = '0;
    else if (p_grant && (starve_q != SMAX))
      starve_d = starve_q + 1'b1;

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (q_grant) begin
      rf_we_d   = (head_da != '0);
      rf_addr_d = head_da;
      rf_data_d = head_data;
    end else if (p_grant) begin
      rf_we_d   = 1'b1;
      rf_addr_d = pipe_da;
      rf_data_d = pipe_bus_d;
    end else if (byp_grant) begin
      rf_we_d   = (mc_da != '0);
      rf_addr_d = mc_da;
      rf_data_d = mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_da_q[wr_ptr_q]   <= mc_da;
      mem_data_q[wr_ptr_q] <= mc_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Walk slots from the head; only the first count_q slots hold live entries.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    q_busy_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q)
        q_busy_mask[mem_da_q[idx]] = 1'b1;
    end
  end

  assign q_count = count_q;
  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

endmodule

// File: doc/risc_wb_port_arbiter.md
Name: risc_wb_port_arbiter

Overview:
- Schedules the single register-file write port between two sources:
  - the pipeline writeback result (WB_Bus_D path);
  - results from a multi-cycle unit (mul/div), which arrive out of band.
- Buffers multi-cycle results in a small FIFO and stalls the pipeline when a queued result takes the port.
- Bounds starvation with a counter.
- Exports a pending-destination mask for hazard detection.
- Sits between the WB stage and the register file.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- QDEPTH, 2, multi-cycle result FIFO depth (power of 2, ≥2)
- STARVE_MAX, 3, consecutive cycles a non-empty queue may lose arbitration before it is forced to win

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_rw  in  1  pipeline WB write request (WB_RW)
- pipe_da  in  ADDR_W  pipeline destination register
- pipe_bus_d  in  DATA_W  pipeline write data (WB_Bus_D)
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  FIFO can accept (combinational: count < QDEPTH)
- mc_da  in  ADDR_W  multi-cycle destination register
- mc_data  in  DATA_W  multi-cycle result
- pipe_stall  out  1  hold the WB stage this cycle (combinational)
- rf_we  out  1  registered register-file write enable
- rf_addr  out  ADDR_W  registered write address
- rf_data  out  DATA_W  registered write data
- q_count  out  clog2(QDEPTH+1)  FIFO occupancy
- q_busy_mask  out  2^ADDR_W  OR of one-hot decoded destinations of valid FIFO entries

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; pending entries discarded.
  - Starvation counter cleared.
  - Outputs: rf_we=0, rf_addr=0, rf_data=0, q_count=0, q_busy_mask=0, pipe_stall=0, mc_ready=1 once reset releases.
- Push: on a rising edge with mc_valid & mc_ready, {mc_da, mc_data} is written at the tail. There is no push when full.
- Write to R0 is never performed:
  - A pipeline request with pipe_da=0 is treated as no request.
  - A FIFO head with da=0 is popped when granted, with rf_we=0.
- Arbitration, combinational each cycle. Let preq = pipe_rw & (pipe_da≠0) and qreq = (q_count≠0).
  - qreq & (!preq | starve==STARVE_MAX) → queue grant: pop head on the next edge, pipe_stall = preq.
  - otherwise preq → pipeline grant, pipe_stall=0.
  - neither → idle.
- Starvation counter (starve):
  - Increments, saturating, on edges where qreq & pipeline grant.
  - Cleared on a queue grant or when qreq=0.
- Write port registered:
  - Each edge, rf_we/rf_addr/rf_data load from the granted source.
  - On idle, rf_we=0 and addr/data hold their previous values.
- Latency:
  - Pipeline request → rf_we one cycle later.
  - mc handshake at edge k → earliest rf_we in the cycle after edge k+1.
- Simultaneous push and pop: allowed. q_count is unchanged; the pointers wrap modulo QDEPTH.
- Full (q_count==QDEPTH): mc_ready=0 and mc_valid is held by the producer. A pop in the same cycle does not raise mc_ready combinationally.
- Stalled pipeline: holds pipe_rw/pipe_da/pipe_bus_d stable; that request is re-arbitrated the next cycle.
- q_busy_mask and q_count reflect registered FIFO state only (updated after the edge).

Optional Feature:
- Macro RISC_WB_ARB_BYPASS_EN.
- Defined:
  - When q_count==0, !preq and mc_valid=1, the mc result is granted directly.
  - It is written to rf_* on the same edge as its handshake and is not enqueued.
  - Latency handshake→rf_we is 1 cycle.
- Undefined: every mc result passes through the FIFO; minimum latency is 2 cycles.

Test Plan:
- Reset: assert reset=0 mid-traffic with 2 entries queued.
  - Required: rf_we=0, q_count=0 and q_busy_mask=0 immediately (asynchronous), and no write of the discarded entries after release.
- Pipeline only: pipe_rw=1, pipe_da=7, pipe_bus_d=0x0000_00A5.
  - Required: the next cycle rf_we=1, rf_addr=7, rf_data=0xA5, with pipe_stall never asserted.
- Queue priority on an idle pipe: push da=3 data=0x1234 while pipe_rw=0.
  - Required: rf_we=1, rf_addr=3, rf_data=0x1234 two cycles after the handshake (one cycle with BYPASS_EN), and q_busy_mask bit 3 set only while the entry is queued.
- Starvation: pipe_rw=1 continuously with da=5, one entry queued with da=9, STARVE_MAX=3.
  - Required: the pipeline wins 3 cycles, then the queue wins with pipe_stall=1 for exactly 1 cycle, rf_addr=9; then the pipeline resumes with rf_addr=5.
- Full/back-pressure: push 2 entries with no pops (pipe busy, STARVE_MAX large).
  - Required: q_count=2 and mc_ready=0, and a third mc_valid is not accepted until after a pop edge.
- R0 suppression: pipe_rw=1 with pipe_da=0, and a queued entry with da=0.
  - Required: rf_we stays 0 in both cases, the entry is popped (q_count decrements), and pipe_stall=0.
